// File: rtl/ram_arb_2p.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Ports may lock the RAM across several accesses. Unlocked contention
// alternates between the ports through a round-robin pointer. Read data
// is steered back to the port that issued the read.
module ram_arb_2p #(
  parameter int AW = 6,
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] di0,
  input  logic [DW-1:0] di1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          vld0,
  output logic          vld1,
  output logic [DW-1:0] do0,
  output logic [DW-1:0] do1,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            vld0_q, vld0_d;
  logic            vld1_q, vld1_d;
  logic [DW-1:0]   do0_q, do0_d;
  logic [DW-1:0]   do1_q, do1_d;

  // Arbitration: pick the granted port, then derive next ownership and pointer.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    ptr_d   = ptr_q;

    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          gnt0 = ~ptr_q;
          gnt1 = ptr_q;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
      OWN0:    gnt0 = req0;
      OWN1:    gnt1 = req1;
      default: ;
    endcase

    // No access may start while reset is held, even though gnt is combinational.
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    // A locked transfer keeps (or takes) ownership; an unlocked one releases
    // the RAM and hands priority to the other port.
    if (gnt0) begin
      if (lock0) begin
        state_d = OWN0;
      end else begin
        state_d = IDLE;
        ptr_d   = 1'b1;
      end
    end else if (gnt1) begin
      if (lock1) begin
        state_d = OWN1;
      end else begin
        state_d = IDLE;
        ptr_d   = 1'b0;
      end
    end
  end

  // RAM drive: route the granted port; the write strobe is only raised on a grant.
  always_comb begin
    ram_we   = (gnt0 & we0) | (gnt1 & we1);
    ram_addr = gnt1 ? addr1 : addr0;
    ram_di   = gnt1 ? di1   : di0;
  end

  // Read return: ram_do is already a registered RAM output one cycle after the
  // grant, so it is forwarded directly while vld is high and latched into a
  // hold register so the port output keeps its last value afterwards.
  always_comb begin
    vld0_d = gnt0 & ~we0;
    vld1_d = gnt1 & ~we1;
    do0_d  = vld0_q ? ram_do : do0_q;
    do1_d  = vld1_q ? ram_do : do1_q;
    vld0   = vld0_q;
    vld1   = vld1_q;
    do0    = do0_d;
    do1    = do1_d;
  end

  // State registers; reset drops ownership and any in-flight read return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
      do0_q   <= '0;
      do1_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vld0_q  <= vld0_d;
      vld1_q  <= vld1_d;
      do0_q   <= do0_d;
      do1_q   <= do1_d;
    end
  end

endmodule

// File: tb/tb_ram_arb_2p.sv
// Bench for ram_arb_2p: a behavioural RAM, a read-data scoreboard, and
// directed arbitration scenarios.
module tb_ram_arb_2p;
  localparam int AW = 6;
  localparam int DW = 20;

  logic          clk;
  logic          rst_n;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] di0, di1;
  logic          gnt0, gnt1, vld0, vld1;
  logic [DW-1:0] do0, do1;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          exp_v0 = 1'b0;
  logic          exp_v1 = 1'b0;

  ram_arb_2p #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .di0(di0), .di1(di1), .gnt0(gnt0), .gnt1(gnt1),
    .vld0(vld0), .vld1(vld1), .do0(do0), .do1(do1),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    logic [DW-1:0] w;
    w = DW'(i * 20'h00313) ^ 20'h5A5A5;
    if (i == 0) w = 20'h0400D;
    return w;
  endfunction

  // Single-port RAM, synchronous read-first, one cycle latency.
  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
    ram_do = '0;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_di;
    ram_do <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: reads push expected data on grant, vld pops and compares.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst_n) begin
      chk("rst_vld0", vld0, 0);
      chk("rst_vld1", vld1, 0);
      exp_v0 = 1'b0;
      exp_v1 = 1'b0;
      q0.delete();
      q1.delete();
    end else begin
      chk("sb_vld0", vld0, exp_v0);
      chk("sb_vld1", vld1, exp_v1);
      if (exp_v0) begin e = q0.pop_front(); chk("sb_do0", do0, e); end
      if (exp_v1) begin e = q1.pop_front(); chk("sb_do1", do1, e); end
      chk("one_gnt", gnt0 & gnt1, 0);
      chk("gnt_noreq", (gnt0 & ~req0) | (gnt1 & ~req1), 0);
      exp_v0 = gnt0 & req0 & ~we0;
      exp_v1 = gnt1 & req1 & ~we1;
      if (exp_v0) q0.push_back(shadow[addr0]);
      if (exp_v1) q1.push_back(shadow[addr1]);
      if (gnt0 && req0) $display("txn p0 %s addr=%h data=%h", we0 ? "wr" : "rd", addr0, we0 ? di0 : shadow[addr0]);
      if (gnt1 && req1) $display("txn p1 %s addr=%h data=%h", we1 ? "wr" : "rd", addr1, we1 ? di1 : shadow[addr1]);
      if (gnt0 && req0 && we0) shadow[addr0] = di0;
      if (gnt1 && req1 && we1) shadow[addr1] = di1;
    end
  end

  task automatic clear_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; di0 = '0; di1 = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    clear_inputs();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    #2 rst_n = 1'b0;
    // Requests during reset must not be granted.
    req0 = 1; req1 = 1; we0 = 1; we1 = 1;
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_do0", do0, 0);
    chk("rst_do1", do1, 0);
    clear_inputs();
    step();
    rst_n = 1'b1;

    // Single read from port 0, first cycle after reset.
    req0 = 1; addr0 = 0;
    @(negedge clk);
    chk("rd0_gnt0", gnt0, 1);
    chk("rd0_gnt1", gnt1, 0);
    chk("rd0_ram_addr", ram_addr, 0);
    chk("rd0_ram_we", ram_we, 0);
    step(); req0 = 0;
    @(negedge clk);
    chk("rd0_vld0", vld0, 1);
    chk("rd0_do0", do0, 20'h0400D);
    chk("rd0_vld1", vld1, 0);
    step();
    @(negedge clk);
    chk("rd0_vld0_drop", vld0, 0);
    chk("rd0_do0_hold", do0, 20'h0400D);

    // Contending reads alternate from ptr=0.
    do_reset();
    req0 = 1; req1 = 1; addr0 = 3; addr1 = 7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_gnt0", gnt0, (i % 2 == 0));
      chk("rr_gnt1", gnt1, (i % 2 == 1));
      if (i > 0) begin
        chk("rr_vld0", vld0, ((i - 1) % 2 == 0));
        chk("rr_vld1", vld1, ((i - 1) % 2 == 1));
      end
      step();
      if (i == 3) begin req0 = 0; req1 = 0; end
    end
    @(negedge clk);
    chk("rr_vld1_last", vld1, 1);
    chk("rr_vld0_last", vld0, 0);

    // Write by port 1 then read-back by port 0 on the next cycle.
    step(); req1 = 1; we1 = 1; addr1 = 5; di1 = 20'h12345;
    @(negedge clk);
    chk("wr_gnt1", gnt1, 1);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 5);
    chk("wr_ram_di", ram_di, 20'h12345);
    step(); req1 = 0; we1 = 0; req0 = 1; addr0 = 5;
    @(negedge clk);
    chk("wr_rb_gnt0", gnt0, 1);
    chk("wr_no_vld1", vld1, 0);
    step(); req0 = 0;
    @(negedge clk);
    chk("wr_rb_vld0", vld0, 1);
    chk("wr_rb_do0", do0, 20'h12345);

    // Port 1 locks the RAM; port 0 waits until the unlocked write.
    step(); req0 = 1; addr0 = 2; req1 = 1; lock1 = 1; addr1 = 9;
    @(negedge clk);
    chk("lk_gnt1", gnt1, 1);
    chk("lk_gnt0", gnt0, 0);
    step(); req1 = 0; lock1 = 0;
    @(negedge clk);
    chk("lk_own_gnt0", gnt0, 0);
    chk("lk_own_gnt1", gnt1, 0);
    step(); req1 = 1; we1 = 1; di1 = 20'hABCDE;
    @(negedge clk);
    chk("lk_wr_gnt1", gnt1, 1);
    chk("lk_wr_gnt0", gnt0, 0);
    chk("lk_wr_ram_we", ram_we, 1);
    step(); req1 = 0; we1 = 0;
    @(negedge clk);
    chk("lk_rel_gnt0", gnt0, 1);
    step(); req0 = 0;
    @(negedge clk);
    chk("lk_rel_vld0", vld0, 1);

    // Reset while port 0 owns the RAM with a read in flight.
    step(); req0 = 1; lock0 = 1; addr0 = 0;
    @(negedge clk);
    chk("own0_gnt0", gnt0, 1);
    step(); addr0 = 1; req1 = 1; addr1 = 9;
    @(negedge clk);
    chk("own0_rd_gnt0", gnt0, 1);
    chk("own0_rd_gnt1", gnt1, 0);
    step(); rst_n = 1'b0; req0 = 0; lock0 = 0;
    #1;
    chk("mid_rst_vld0", vld0, 0);
    chk("mid_rst_do0", do0, 0);
    chk("mid_rst_gnt1", gnt1, 0);
    step(); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt1", gnt1, 1);
    step(); req1 = 0;
    @(negedge clk);
    chk("post_rst_vld1", vld1, 1);
    chk("post_rst_do1", do1, 20'hABCDE);

    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arb_2p.md
RAM_ARB_2P -- requirements
Module: ram_arb_2p

Interface
REQ-001 Parameter AW, default 6, RAM address width (64 words).
REQ-002 Parameter DW, default 20, RAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0/req1  input  1  port k requests one RAM access.
REQ-006 we0/we1  input  1  port k access is a write (1) or a read (0).
REQ-007 lock0/lock1  input  1  port k retains RAM ownership after this access.
REQ-008 addr0/addr1  input  AW  port k word address.
REQ-009 di0/di1  input  DW  port k write data.
REQ-010 gnt0/gnt1  output  1  port k access accepted this cycle (combinational).
REQ-011 vld0/vld1  output  1  port k read data valid (registered).
REQ-012 do0/do1  output  DW  port k read data (registered).
REQ-013 ram_we  output  1  RAM write enable.
REQ-014 ram_addr  output  AW  RAM address.
REQ-015 ram_di  output  DW  RAM write data.
REQ-016 ram_do  input  DW  RAM read data; synchronous read, 1-cycle latency, read-first.

Function
REQ-017 Handshake: a transfer on port k occurs in a cycle with reqk=1 and gntk=1; requester holds req/we/lock/addr/di stable until granted; at most one gnt per cycle.
REQ-018 Arbiter states: IDLE, OWN0, OWN1.
REQ-019 In IDLE with one request, that port is granted; with both, port ptr is granted; with none, no grant.
REQ-020 In OWNk only port k may be granted, and it is granted whenever reqk=1; the other port waits regardless of ptr.
REQ-021 On an IDLE transfer by port k with lockk=1, state <= OWNk; with lockk=0, state stays IDLE.
REQ-022 In OWNk, a port-k transfer with lockk=0 moves state to IDLE; reqk=0 cycles keep state OWNk with no grant.
REQ-023 After any transfer by port k that leaves the arbiter in IDLE, ptr <= 1-k; ptr is unchanged otherwise.
REQ-024 RAM drive: in a grant cycle ram_addr/ram_di = granted port's addr/di and ram_we = granted port's we; without a grant, ram_we=0 (ram_addr/ram_di don't-care).
REQ-025 A granted read from port k in cycle N gives vldk=1 and dok=ram_do in cycle N+1 only; vldk=0 in all other cycles.
REQ-026 dok holds its last value when vldk=0.
REQ-027 Writes produce no vld pulse.
REQ-028 Throughput: one access per cycle sustained; back-to-back reads return data on consecutive cycles.
REQ-029 A write then a read to the same address in consecutive cycles returns the new data.

Reset
REQ-030 While rst_n=0: state=IDLE, ptr=0, vld0=vld1=0, do0=do1=0, gnt0=gnt1=0, ram_we=0.
REQ-031 Reset assertion mid-operation clears lock ownership and suppresses a pending vld.
REQ-032 The first rising edge after rst_n deasserts arbitrates normally.

Verification
REQ-033 Bench RAM model holds addr0=20'h0400D. Reset, then req0 read addr 0 alone -> gnt0 same cycle; next cycle vld0=1, do0=20'h0400D; vld1 stays 0.
REQ-034 req0 and req1 reads held for 4 cycles after reset -> grants alternate 0,1,0,1 and vld0/vld1 alternate one cycle later.
REQ-035 Port 1 writes addr 5 = 20'h12345, then port 0 reads addr 5 the next cycle -> do0=20'h12345.
REQ-036 Port 1 locked read (lock1=1) of addr 9, with req0 held throughout -> gnt0 stays 0; then port 1 writes addr 9 with lock1=0 -> state IDLE; next cycle gnt0=1.
REQ-037 rst_n pulled low in the cycle after a granted read while in OWN0 -> vld0=0, do0=0 immediately; after release, req1 is granted in the first cycle.
